// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 controller parameters and state type
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_DW = 128;
  localparam int AES_RW = 4;

  typedef enum logic [1:0] {
    CTRL_IDLE   = 2'd0,
    CTRL_KEYEXP = 2'd1,
    CTRL_ROUND  = 2'd2,
    CTRL_DONE   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/aes_key_buffer.sv
// rtl/aes_key_buffer.sv - (NR+1) round-key registers, one write port, one combinational read port
module aes_key_buffer
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int DW = AES_DW,
  parameter int RW = AES_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic [RW-1:0] rd_idx,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] key_regs [NR+1]
);

  logic [DW-1:0] buf_q [NR+1];
  logic [DW-1:0] buf_d [NR+1];

  // Next buffer contents: at most one round key written per cycle
  always_comb begin
    buf_d = buf_q;
    if (wr_en && (wr_idx <= RW'(NR))) begin
      buf_d[wr_idx] = wr_data;
    end
  end

  // Key storage, cleared on reset so a stale key never leaks into a new job
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '{default: '0};
    end else begin
      buf_q <= buf_d;
    end
  end

  assign rd_data  = (rd_idx <= RW'(NR)) ? buf_q[rd_idx] : '0;
  assign key_regs = buf_q;

endmodule

// File: rtl/aes_round_controller.sv
// rtl/aes_round_controller.sv - AES-128 job sequencer: key expansion handshake, key cache, round strobes
module aes_round_controller
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int DW = AES_DW,
  parameter int RW = AES_RW
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          enable,
  input  logic          encrypt,
  input  logic [DW-1:0] inputData,
  input  logic [DW-1:0] keyWord,
  output logic          ke_req,
  output logic [DW-1:0] ke_prev,
  output logic [RW-1:0] ke_idx,
  input  logic          ke_ack,
  input  logic [DW-1:0] ke_key,
  output logic          dp_load,
  output logic          dp_round_en,
  output logic          dp_final,
  output logic          dp_decrypt,
  output logic [DW-1:0] dp_data,
  output logic [DW-1:0] dp_key,
  input  logic [DW-1:0] dp_state,
  output logic [DW-1:0] result,
  output logic          done,
  output logic          busy,
  output logic          key_valid
);

  ctrl_state_t   state_q, state_d;
  logic          enable_q, enable_d;
  logic          busy_q, busy_d;
  logic          key_valid_q, key_valid_d;
  logic [DW-1:0] cached_key_q, cached_key_d;
  logic [DW-1:0] data_q, data_d;
  logic          decrypt_q, decrypt_d;
  logic [RW-1:0] k_q, k_d;
  logic [RW-1:0] r_q, r_d;
  logic          gap_q, gap_d;
  logic [DW-1:0] result_q, result_d;
  logic          done_q, done_d;

  logic          start;
  logic          wr_en;
  logic [RW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic [RW-1:0] rd_idx;
  logic [DW-1:0] rd_data;
  logic [RW-1:0] prev_idx;
  logic [DW-1:0] key_regs [NR+1];

  aes_key_buffer #(
    .NR(NR),
    .DW(DW),
    .RW(RW)
  ) u_key_buffer (
    .clk     (HCLK),
    .rst     (HRESET),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .key_regs(key_regs)
  );

  assign start = enable & ~enable_q;

  // Next-state logic: job latch, cache decision, expansion handshake and round counting
  always_comb begin
    state_d      = state_q;
    enable_d     = enable;
    busy_d       = busy_q;
    key_valid_d  = key_valid_q;
    cached_key_d = cached_key_q;
    data_d       = data_q;
    decrypt_d    = decrypt_q;
    k_d          = k_q;
    r_d          = r_q;
    gap_d        = gap_q;
    result_d     = result_q;
    done_d       = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = k_q;
    wr_data      = ke_key;

    case (state_q)
      CTRL_IDLE: begin
        if (start) begin
          data_d    = inputData;
          decrypt_d = ~encrypt;
          busy_d    = 1'b1;
          r_d       = '0;
          if (key_valid_q && (keyWord == cached_key_q)) begin
            state_d = CTRL_ROUND;
          end else begin
            key_valid_d = 1'b0;
            wr_en       = 1'b1;
            wr_idx      = '0;
            wr_data     = keyWord;
            k_d         = RW'(1);
            gap_d       = 1'b0;
            state_d     = CTRL_KEYEXP;
          end
        end
      end

      CTRL_KEYEXP: begin
        // The request drops for one cycle after every ack so the unit sees a fresh request edge
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (ke_ack) begin
          wr_en   = 1'b1;
          wr_idx  = k_q;
          wr_data = ke_key;
          if (k_q == RW'(NR)) begin
            key_valid_d  = 1'b1;
            cached_key_d = key_regs[0];
            r_d          = '0;
            state_d      = CTRL_ROUND;
          end else begin
            k_d   = k_q + RW'(1);
            gap_d = 1'b1;
          end
        end
      end

      CTRL_ROUND: begin
        if (r_q == RW'(NR)) begin
          state_d = CTRL_DONE;
        end else begin
          r_d = r_q + RW'(1);
        end
      end

      CTRL_DONE: begin
        result_d = dp_state;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = CTRL_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = CTRL_IDLE;
      end
    endcase
  end

  // Controller registers; reset abandons any job in flight without a done pulse
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= CTRL_IDLE;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      key_valid_q  <= 1'b0;
      cached_key_q <= '0;
      data_q       <= '0;
      decrypt_q    <= 1'b0;
      k_q          <= '0;
      r_q          <= '0;
      gap_q        <= 1'b0;
      result_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      key_valid_q  <= key_valid_d;
      cached_key_q <= cached_key_d;
      data_q       <= data_d;
      decrypt_q    <= decrypt_d;
      k_q          <= k_d;
      r_q          <= r_d;
      gap_q        <= gap_d;
      result_q     <= result_d;
      done_q       <= done_d;
    end
  end

  // Decrypt walks the key schedule backwards
  assign rd_idx   = decrypt_q ? (RW'(NR) - r_q) : r_q;
  assign prev_idx = k_q - RW'(1);

  assign ke_req      = (state_q == CTRL_KEYEXP) && !gap_q;
  assign ke_idx      = (state_q == CTRL_KEYEXP) ? k_q : '0;
  assign ke_prev     = ((state_q == CTRL_KEYEXP) && (prev_idx <= RW'(NR))) ? key_regs[prev_idx] : '0;

  assign dp_load     = (state_q == CTRL_ROUND) && (r_q == '0);
  assign dp_round_en = (state_q == CTRL_ROUND) && (r_q != '0) && (r_q != RW'(NR));
  assign dp_final    = (state_q == CTRL_ROUND) && (r_q == RW'(NR));
  assign dp_key      = (state_q == CTRL_ROUND) ? rd_data : '0;
  assign dp_decrypt  = decrypt_q;
  assign dp_data     = data_q;

  assign result      = result_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_aes_round_controller.sv
// tb/tb_aes_round_controller.sv - scoreboard bench with reference key-expansion and round-datapath models
module tb_aes_round_controller;

  localparam int NR = 10;
  localparam int DW = 128;
  localparam int RW = 4;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          enable = 1'b0;
  logic          encrypt = 1'b0;
  logic [DW-1:0] inputData = '0;
  logic [DW-1:0] keyWord = '0;
  logic          ke_req;
  logic [DW-1:0] ke_prev;
  logic [RW-1:0] ke_idx;
  logic          ke_ack = 1'b0;
  logic [DW-1:0] ke_key = '0;
  logic          dp_load, dp_round_en, dp_final, dp_decrypt;
  logic [DW-1:0] dp_data, dp_key;
  logic [DW-1:0] dp_state = '0;
  logic [DW-1:0] result;
  logic          done, busy, key_valid;

  aes_round_controller dut (
    .HCLK(HCLK), .HRESET(HRESET), .enable(enable), .encrypt(encrypt),
    .inputData(inputData), .keyWord(keyWord),
    .ke_req(ke_req), .ke_prev(ke_prev), .ke_idx(ke_idx), .ke_ack(ke_ack), .ke_key(ke_key),
    .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_final(dp_final), .dp_decrypt(dp_decrypt),
    .dp_data(dp_data), .dp_key(dp_key), .dp_state(dp_state),
    .result(result), .done(done), .busy(busy), .key_valid(key_valid)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [DW-1:0] res;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            ack_lat = 1;
  bit            spurious = 1'b0;
  bit            model_kv = 1'b0;
  logic [DW-1:0] model_key = '0;
  logic [DW-1:0] exp_rk [NR+1];
  bit            exp_dec = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic [7:0]    sbox [256];
  logic [7:0]    inv_sbox [256];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv, s, v;
    for (int x = 0; x < 256; x++) begin
      v = 8'(x);
      inv = 8'h01;
      if (x == 0) inv = 8'h00;
      else for (int i = 0; i < 254; i++) inv = gm(inv, v);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = s;
      inv_sbox[s] = v;
    end
  endfunction

  function automatic logic [DW-1:0] sub_shift(input logic [DW-1:0] s, input bit inv);
    logic [DW-1:0] o;
    int src, dst;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!inv) begin
          dst = c * 4 + r;
          src = ((c + r) % 4) * 4 + r;
          o[127-8*dst -: 8] = sbox[s[127-8*src -: 8]];
        end else begin
          src = c * 4 + r;
          dst = ((c + r) % 4) * 4 + r;
          o[127-8*dst -: 8] = inv_sbox[s[127-8*src -: 8]];
        end
      end
    end
    return o;
  endfunction

  function automatic logic [DW-1:0] mix(input logic [DW-1:0] s, input bit inv);
    logic [7:0] m [4];
    logic [7:0] a [4];
    logic [7:0] v;
    logic [DW-1:0] o;
    if (inv) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(c*4+j) -: 8];
      for (int r = 0; r < 4; r++) begin
        v = 8'h00;
        for (int j = 0; j < 4; j++) v = v ^ gm(a[j], m[(j - r + 4) % 4]);
        o[127-8*(c*4+r) -: 8] = v;
      end
    end
    return o;
  endfunction

  function automatic logic [DW-1:0] ke_step(input logic [DW-1:0] p, input int k);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 1; i < k; i++) rc = xt(rc);
    t  = {sbox[p[23:16]], sbox[p[15:8]], sbox[p[7:0]], sbox[p[31:24]]} ^ {rc, 24'h0};
    w0 = p[127:96] ^ t;
    w1 = p[95:64] ^ w0;
    w2 = p[63:32] ^ w1;
    w3 = p[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Whole-block reference cipher used to predict the result of a job
  function automatic logic [DW-1:0] ref_cipher(input logic [DW-1:0] key, input logic [DW-1:0] data, input bit enc);
    logic [DW-1:0] rk [NR+1];
    logic [DW-1:0] s;
    rk[0] = key;
    for (int k = 1; k <= NR; k++) rk[k] = ke_step(rk[k-1], k);
    if (enc) begin
      s = data ^ rk[0];
      for (int r = 1; r < NR; r++) s = mix(sub_shift(s, 0), 0) ^ rk[r];
      s = sub_shift(s, 0) ^ rk[NR];
    end else begin
      s = data ^ rk[NR];
      for (int r = 1; r < NR; r++) s = mix(sub_shift(s, 1) ^ rk[NR-r], 1);
      s = sub_shift(s, 1) ^ rk[0];
    end
    return s;
  endfunction

  // ---------------- environment processes ----------------
  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  // Key-expansion unit model with programmable ack latency and optional spurious acks
  initial begin
    int req_cnt;
    req_cnt = 0;
    forever begin
      @(negedge HCLK);
      if (ke_req) begin
        req_cnt++;
        if (req_cnt >= ack_lat) begin
          if (ke_idx >= 1 && ke_idx <= NR) begin
            check("ke_prev", ke_prev, exp_rk[ke_idx-1]);
          end else begin
            check("ke_idx_range", DW'(ke_idx), DW'(1));
          end
          ke_ack  = 1'b1;
          ke_key  = ke_step(ke_prev, int'(ke_idx));
          req_cnt = 0;
        end else begin
          ke_ack = 1'b0;
        end
      end else begin
        req_cnt = 0;
        ke_ack  = spurious && dp_round_en;
        ke_key  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Round datapath model driven by the strobes
  initial begin
    logic [DW-1:0] st;
    int nstrb;
    st = '0;
    forever begin
      @(negedge HCLK);
      nstrb = int'(dp_load) + int'(dp_round_en) + int'(dp_final);
      if (nstrb != 0) begin
        check("one_strobe", DW'(nstrb), DW'(1));
        check("dp_decrypt", DW'(dp_decrypt), DW'(exp_dec));
        check("dp_data", dp_data, exp_data);
        if (dp_load) st = dp_data ^ dp_key;
        else if (dp_round_en) st = dp_decrypt ? mix(sub_shift(st, 1) ^ dp_key, 1) : (mix(sub_shift(st, 0), 0) ^ dp_key);
        else st = dp_decrypt ? (sub_shift(st, 1) ^ dp_key) : (sub_shift(st, 0) ^ dp_key);
      end
      dp_state = st;
    end
  end

  // Scoreboard monitor: every done pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
        end else begin
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("done_cycle", DW'(cyc), DW'(e.cyc));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic launch(input logic [DW-1:0] key, input logic [DW-1:0] data, input bit enc, input bit use_ref,
                        input logic [DW-1:0] fixed_res);
    exp_t e;
    bit   cached;
    int   lat;
    cached = model_kv && (key == model_key);
    lat = cached ? (NR + 2) : (NR * ack_lat + (NR - 1) + NR + 2);
    exp_rk[0] = key;
    for (int k = 1; k <= NR; k++) exp_rk[k] = ke_step(exp_rk[k-1], k);
    exp_dec   = !enc;
    exp_data  = data;
    e.res     = use_ref ? ref_cipher(key, data, enc) : fixed_res;
    e.cyc     = cyc + 1 + lat;
    exp_q.push_back(e);
    model_kv  = 1'b1;
    model_key = key;
    keyWord   = key;
    inputData = data;
    encrypt   = enc;
    enable    = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge HCLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("job_timeout", DW'(exp_q.size()), DW'(0));
      exp_q.delete();
    end
    @(negedge HCLK);
  endtask

  task automatic run_job(input logic [DW-1:0] key, input logic [DW-1:0] data, input bit enc);
    launch(key, data, enc, 1'b1, '0);
    @(negedge HCLK);
    enable = 1'b0;
    wait_idle(200);
  endtask

  initial begin
    logic [DW-1:0] k_fips, pt_fips, ct_fips, k2, d;
    int n;
    k_fips  = 128'h000102030405060708090a0b0c0d0e0f;
    pt_fips = 128'h00112233445566778899aabbccddeeff;
    ct_fips = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    build_sbox();

    repeat (3) @(negedge HCLK);
    check("rst_busy", DW'(busy), '0);
    check("rst_done", DW'(done), '0);
    check("rst_key_valid", DW'(key_valid), '0);
    check("rst_ke_req", DW'(ke_req), '0);
    check("rst_strobes", DW'({dp_load, dp_round_en, dp_final, dp_decrypt}), '0);
    check("rst_result", result, '0);
    check("rst_ke_prev", ke_prev, '0);
    HRESET = 1'b0;
    @(negedge HCLK);

    // FIPS-197 C.1 encrypt, uncached, 1-cycle acks
    launch(k_fips, pt_fips, 1'b1, 1'b0, ct_fips);
    @(negedge HCLK);
    enable = 1'b0;
    check("busy_after_start", DW'(busy), DW'(1));
    wait_idle(200);
    check("key_valid_after_exp", DW'(key_valid), DW'(1));

    // Decrypt with the cached key
    launch(k_fips, ct_fips, 1'b0, 1'b0, pt_fips);
    @(negedge HCLK);
    enable = 1'b0;
    wait_idle(200);

    // Slow key expansion with spurious acks during rounds
    ack_lat  = 3;
    spurious = 1'b1;
    run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    ack_lat  = 1;

    // Start edge and input changes while busy are ignored
    launch(model_key, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, '0);
    @(negedge HCLK);
    enable = 1'b0;
    repeat (3) @(negedge HCLK);
    enable    = 1'b1;
    keyWord   = ~keyWord;
    encrypt   = ~encrypt;
    inputData = ~inputData;
    @(negedge HCLK);
    enable = 1'b0;
    wait_idle(200);

    // Reset during KEYEXP at k=5
    launch({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, '0);
    @(negedge HCLK);
    enable = 1'b0;
    n = 0;
    while (!(ke_req && ke_idx == RW'(5)) && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    check("reach_k5", DW'(ke_idx), DW'(5));
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    exp_q.delete();
    model_kv = 1'b0;
    check("midrst_busy", DW'(busy), '0);
    check("midrst_ke_req", DW'(ke_req), '0);
    check("midrst_key_valid", DW'(key_valid), '0);
    check("midrst_result", result, '0);
    repeat (40) @(negedge HCLK);
    run_job(exp_rk[0], exp_data, 1'b1);

    // Enable held high across job end: exactly one start
    launch(model_key, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, '0);
    wait_idle(200);
    repeat (20) @(negedge HCLK);
    check("held_enable_busy", DW'(busy), '0);
    enable = 1'b0;
    @(negedge HCLK);
    run_job(model_key, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 12; j++) begin
      ack_lat  = $urandom_range(1, 4);
      spurious = $urandom_range(0, 1);
      k2 = ($urandom_range(0, 1) == 1) ? model_key : {$urandom, $urandom, $urandom, $urandom};
      d  = {$urandom, $urandom, $urandom, $urandom};
      run_job(k2, d, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge HCLK);
    check("queue_empty", DW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
